// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and sizing helpers for the AXI-Stream packet generator.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    GAP      = 2'd2,
    WAIT_END = 2'd3
  } pkt_state_e;

  // Widest size/keep the helpers handle; callers cast down to their widths.
  localparam int LEN_MAX  = 32;
  localparam int KEEP_MAX = 16;

  // ceil(size / 2**lg_bpb), one bit wider than any LEN_W so it cannot overflow.
  function automatic logic [LEN_MAX:0] pkt_beats(input logic [LEN_MAX:0] size,
                                                 input int unsigned      lg_bpb);
    logic [LEN_MAX:0] mask;
    mask = ~({(LEN_MAX+1){1'b1}} << lg_bpb);
    return (size + mask) >> lg_bpb;
  endfunction

  // Keep mask of the final beat: low (size mod bpb) bytes, or all bytes when even.
  function automatic logic [KEEP_MAX-1:0] pkt_last_keep(input logic [LEN_MAX:0] size,
                                                        input int unsigned      lg_bpb);
    logic [LEN_MAX:0]  mask;
    logic [LEN_MAX:0]  rem;
    logic [KEEP_MAX:0] full;
    logic [KEEP_MAX:0] part;
    mask = ~({(LEN_MAX+1){1'b1}} << lg_bpb);
    rem  = size & mask;
    full = ~({(KEEP_MAX+1){1'b1}} << (1 << lg_bpb));
    part = ~({(KEEP_MAX+1){1'b1}} << rem);
    return (rem == '0) ? full[KEEP_MAX-1:0] : part[KEEP_MAX-1:0];
  endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream master/slave bundle used by the packet generator.
interface axis_pkt_gen_if #(
  parameter int DATA_W = 32
);
  import axis_pkt_gen_pkg::*;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input  tready);
  modport slave  (input  tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen_len.sv
// Packet length latch: captures PacketSize at packet start and provides the
// beat count and last-beat keep mask. On the load cycle the fresh values are
// passed straight through so the first beat's tlast/tkeep can be registered
// at the same edge the size is captured.
module axis_pkt_gen_len
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [LEN_W-1:0]    size_in,
  output logic [LEN_W:0]      beats,
  output logic [DATA_W/8-1:0] keep_last
);
  localparam int          KEEP_W = DATA_W / 8;
  localparam int unsigned LG_BPB = $clog2(KEEP_W);

  logic [LEN_MAX:0]    size_ext;
  logic [LEN_W:0]      beats_new, beats_d, beats_q;
  logic [KEEP_W-1:0]   keep_new, keep_d, keep_q;

  // Clamp zero-length requests to one byte, then size the packet.
  always_comb begin
    size_ext = (LEN_MAX+1)'(size_in);
    if (size_in == '0) size_ext = (LEN_MAX+1)'(1);
    beats_new = (LEN_W+1)'(pkt_beats(size_ext, LG_BPB));
    keep_new  = KEEP_W'(pkt_last_keep(size_ext, LG_BPB));
    beats_d   = load ? beats_new : beats_q;
    keep_d    = load ? keep_new  : keep_q;
    beats     = beats_d;
    keep_last = keep_d;
  end

  // Hold the latched sizing for the rest of the packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
      keep_q  <= '0;
    end else begin
      beats_q <= beats_d;
      keep_q  <= keep_d;
    end
  end
endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator. Emits back-to-back packets of PacketSize bytes
// whose payload is a free-running 32-bit beat counter. Optional inter-packet
// gap is compiled in with AXIS_PKT_GEN_GAP_EN; without it PacketGap is ignored.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [LEN_W-1:0]     PacketSize,
  input  logic [GAP_W-1:0]     PacketGap,
  axis_pkt_gen_if.master       M_AXIS,
  output logic [31:0]          PacketCount,
  output logic                 Busy
);
  localparam int KEEP_W = DATA_W / 8;

  pkt_state_e        state_d, state_q;
  logic              tvalid_d, tvalid_q;
  logic              tlast_d, tlast_q;
  logic [KEEP_W-1:0] tkeep_d, tkeep_q;
  logic [LEN_W:0]    beat_d, beat_q;
  logic [31:0]       gcnt_d, gcnt_q;
  logic [31:0]       pcnt_d, pcnt_q;
  logic              load;
  logic              xfer, last_xfer;
  logic [LEN_W:0]    beats;
  logic [KEEP_W-1:0] keep_last;
`ifdef AXIS_PKT_GEN_GAP_EN
  logic [GAP_W-1:0]  gap_d, gap_q;
`else
  logic              unused_gap;
  assign unused_gap = ^PacketGap;
`endif

  axis_pkt_gen_len #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_len (
    .clk       (Clk),
    .rst       (Reset),
    .load      (load),
    .size_in   (PacketSize),
    .beats     (beats),
    .keep_last (keep_last)
  );

  assign xfer      = tvalid_q & M_AXIS.tready;
  assign last_xfer = xfer & tlast_q;

  // Next state, beat sequencing and registered AXIS outputs.
  always_comb begin
    state_d  = state_q;
    tlast_d  = tlast_q;
    tkeep_d  = tkeep_q;
    beat_d   = beat_q;
    gcnt_d   = gcnt_q + 32'(xfer);
    pcnt_d   = pcnt_q + 32'(last_xfer);
    load     = 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      IDLE: if (En) begin
        state_d = ACTIVE;
        load    = 1'b1;
      end
      ACTIVE: begin
        if (last_xfer) begin
`ifdef AXIS_PKT_GEN_GAP_EN
          if (PacketGap != '0) begin
            state_d = GAP;
            gap_d   = PacketGap;
          end else
`endif
          if (En) begin
            state_d = ACTIVE;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (!En) begin
          state_d = WAIT_END;
        end
      end
      WAIT_END: if (last_xfer) state_d = IDLE;
`ifdef AXIS_PKT_GEN_GAP_EN
      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          gap_d = '0;
          if (En) begin
            state_d = ACTIVE;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // A new packet wins over the clear from the previous packet's last beat.
    if (load) begin
      beat_d  = '0;
      tlast_d = (beats == (LEN_W+1)'(1));
      tkeep_d = tlast_d ? keep_last : '1;
    end else if (last_xfer) begin
      beat_d  = '0;
      tlast_d = 1'b0;
      tkeep_d = '0;
    end else if (xfer) begin
      beat_d  = beat_q + (LEN_W+1)'(1);
      tlast_d = (beat_d == beats - (LEN_W+1)'(1));
      tkeep_d = tlast_d ? keep_last : '1;
    end

    tvalid_d = (state_d == ACTIVE) || (state_d == WAIT_END);
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= '0;
      beat_q   <= '0;
      gcnt_q   <= '0;
      pcnt_q   <= '0;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tkeep_q  <= tkeep_d;
      beat_q   <= beat_d;
      gcnt_q   <= gcnt_d;
      pcnt_q   <= pcnt_d;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  assign M_AXIS.tvalid = tvalid_q;
  assign M_AXIS.tdata  = DATA_W'(gcnt_q);
  assign M_AXIS.tkeep  = tkeep_q;
  assign M_AXIS.tlast  = tlast_q;
  assign PacketCount   = pcnt_q;
  assign Busy          = (state_q != IDLE);
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen (DATA_W=32). Gap expectations follow
// AXIS_PKT_GEN_GAP_EN: 2 idle cycles when defined, none when not.
module tb_axis_pkt_gen;
  import axis_pkt_gen_pkg::*;

  localparam int DW = 32;
`ifdef AXIS_PKT_GEN_GAP_EN
  localparam int GAP_EXP = 2;
`else
  localparam int GAP_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] psize;
  logic [7:0]  pgap;
  logic [31:0] pcount;
  logic        busy;
  int          n_asrt = 0;
  int          n_fail = 0;

  axis_pkt_gen_if #(.DATA_W(DW)) axis ();

  axis_pkt_gen #(.DATA_W(DW), .LEN_W(16), .GAP_W(8)) dut (
    .Clk         (clk),
    .Reset       (rst),
    .En          (en),
    .PacketSize  (psize),
    .PacketGap   (pgap),
    .M_AXIS      (axis),
    .PacketCount (pcount),
    .Busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; axis.tready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lows;
    psize = 16'd10; pgap = 8'd0;
    do_reset();
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast",  axis.tlast, 0);
    check("rst_tdata",  axis.tdata, 0);
    check("rst_tkeep",  axis.tkeep, 0);
    check("rst_pcount", pcount, 0);
    check("rst_busy",   busy, 0);

    // 10-byte packets, gap 0, always ready: 3 beats F,F,3 back to back.
    en = 1'b1; axis.tready = 1'b1;
    check("idle_tvalid", axis.tvalid, 0);
    step();
    for (int i = 0; i < 9; i++) begin
      check("s10_tvalid", axis.tvalid, 1);
      check("s10_tdata",  axis.tdata, i);
      check("s10_tkeep",  axis.tkeep, (i % 3 == 2) ? 4'h3 : 4'hF);
      check("s10_tlast",  axis.tlast, (i % 3 == 2));
      check("s10_pcount", pcount, i / 3);
      step();
    end
    check("s10_pcount_end", pcount, 3);
    check("s10_tdata_end",  axis.tdata, 9);

    // 8-byte packet with tready 1,0,0,1,1 starting at the En cycle.
    do_reset();
    psize = 16'd8; en = 1'b1; axis.tready = 1'b1;
    step();
    check("stall_c2_tdata", axis.tdata, 0);
    check("stall_c2_tkeep", axis.tkeep, 4'hF);
    axis.tready = 1'b0;
    step();
    check("stall_c3_tdata", axis.tdata, 0);
    check("stall_c3_tkeep", axis.tkeep, 4'hF);
    check("stall_c3_tlast", axis.tlast, 0);
    step();
    check("stall_c4_tdata", axis.tdata, 0);
    check("stall_c4_tvalid", axis.tvalid, 1);
    axis.tready = 1'b1;
    step();
    check("stall_c5_tdata", axis.tdata, 1);
    check("stall_c5_tlast", axis.tlast, 1);
    check("stall_c5_tkeep", axis.tkeep, 4'hF);
    step();
    check("stall_pcount", pcount, 1);
    check("stall_next_tdata", axis.tdata, 2);
    check("stall_next_tlast", axis.tlast, 0);

    // En dropped after the first beat of a 16-byte packet.
    do_reset();
    psize = 16'd16; en = 1'b1; axis.tready = 1'b1;
    step();
    check("we_b0_tdata", axis.tdata, 0);
    check("we_b0_busy", busy, 1);
    en = 1'b0;
    for (int i = 1; i < 4; i++) begin
      step();
      check("we_tvalid", axis.tvalid, 1);
      check("we_tdata",  axis.tdata, i);
      check("we_tlast",  axis.tlast, (i == 3));
      check("we_busy",   busy, 1);
    end
    step();
    check("we_end_tvalid", axis.tvalid, 0);
    check("we_end_busy",   busy, 0);
    check("we_end_pcount", pcount, 1);
    step();
    check("we_idle_tvalid", axis.tvalid, 0);

    // 4-byte single-beat packets with PacketGap=2.
    do_reset();
    psize = 16'd4; pgap = 8'd2; en = 1'b1; axis.tready = 1'b1;
    step();
    check("gap_b0_tlast", axis.tlast, 1);
    check("gap_b0_tkeep", axis.tkeep, 4'hF);
    for (int p = 1; p < 3; p++) begin
      step();
      lows = 0;
      while (axis.tvalid !== 1'b1 && lows < 10) begin
        lows++;
        step();
      end
      check("gap_len", lows, GAP_EXP);
      check("gap_next_tdata", axis.tdata, p);
      check("gap_next_tlast", axis.tlast, 1);
    end
    pgap = 8'd0;

    // Size change mid-packet has no effect; next packet uses size 0 -> 1 byte.
    do_reset();
    psize = 16'd10; en = 1'b1; axis.tready = 1'b1;
    step();
    psize = 16'd0;
    step();
    check("mid_b1_tlast", axis.tlast, 0);
    check("mid_b1_tkeep", axis.tkeep, 4'hF);
    step();
    check("mid_b2_tlast", axis.tlast, 1);
    check("mid_b2_tkeep", axis.tkeep, 4'h3);
    step();
    check("z_tdata", axis.tdata, 3);
    check("z_tkeep", axis.tkeep, 4'h1);
    check("z_tlast", axis.tlast, 1);
    step();
    check("z2_tdata",  axis.tdata, 4);
    check("z2_tkeep",  axis.tkeep, 4'h1);
    check("z2_pcount", pcount, 2);

    // Reset in the middle of a packet.
    do_reset();
    psize = 16'd16; en = 1'b1; axis.tready = 1'b1;
    step(); step();
    check("mr_pre_tdata", axis.tdata, 1);
    rst = 1'b1;
    step();
    check("mr_tvalid", axis.tvalid, 0);
    check("mr_tdata",  axis.tdata, 0);
    check("mr_tkeep",  axis.tkeep, 0);
    check("mr_tlast",  axis.tlast, 0);
    check("mr_busy",   busy, 0);
    rst = 1'b0;
    step();
    check("mr_rel_tvalid", axis.tvalid, 1);
    check("mr_rel_tdata",  axis.tdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
